// File: rtl/avalon_region_reader_if.sv
// Avalon-MM read master bus used by avalon_region_reader.
// The master modport belongs to the reader; the slave modport belongs to the memory side.
interface avalon_region_reader_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_acknowledge;

  modport master (
    output avm_address, avm_read, avm_byteenable,
    input  avm_readdata, avm_acknowledge
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable,
    output avm_readdata, avm_acknowledge
  );
endinterface

// File: rtl/avalon_region_reader.sv
// Multi-region SDRAM read engine: walks a runtime region table in index order.
// Each region is either unpacked byte-by-byte into a RAM or streamed beat-wise to a FIFO.
module avalon_region_reader #(
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 26,
  parameter int NUM_REGIONS = 4,
  parameter int LEN_W       = 20,
  parameter int RAM_ADDR_W  = 10,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_mode,
  input  logic                  cfg_en,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      region_idx,
  output logic                  timeout_err,
  avalon_region_reader_if.master avm_bus,
  output logic                  byte_wren,
  output logic [RAM_ADDR_W-1:0] byte_addr,
  output logic [7:0]            byte_data,
  output logic                  beat_valid,
  output logic [DATA_W-1:0]     beat_data,
  input  logic                  beat_full
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int BEAT_W = LEN_W - OFF_W + 1;
  localparam int CNT_W  = OFF_W + 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, SEL, REQ, RD, UNPACK, FIN} state_t;

  // Region table
  logic [ADDR_W-1:0]      tbl_base [NUM_REGIONS];
  logic [LEN_W-1:0]       tbl_len  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] tbl_mode;
  logic [NUM_REGIONS-1:0] tbl_en;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       region_q, region_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BEAT_W-1:0]      beats_q, beats_d;
  logic                   mode_q, mode_d;
  logic [CNT_W-1:0]       last_q, last_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       ucnt_q, ucnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [RAM_ADDR_W-1:0]  byte_addr_q, byte_addr_d;
  logic [7:0]             byte_data_q, byte_data_d;
  logic                   terr_q, terr_d;
  logic                   busy_q, done_q, read_q, wren_q;

  logic [LEN_W-1:0]       sel_len;
  logic [LEN_W:0]         len_round;
  logic [BEAT_W-1:0]      sel_beats;
  logic [CNT_W-1:0]       sel_last;
  logic [CNT_W-1:0]       n_bytes;
  logic                   last_region;
  logic                   ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        tbl_base[i] <= '0;
        tbl_len[i]  <= '0;
      end
      tbl_mode <= '0;
      tbl_en   <= '0;
    end else if (cfg_we && state_q == IDLE) begin
      tbl_base[cfg_idx] <= cfg_base & ~ADDR_W'(BYTES - 1);
      tbl_len[cfg_idx]  <= cfg_len;
      tbl_mode[cfg_idx] <= cfg_mode;
      tbl_en[cfg_idx]   <= cfg_en;
    end
  end

  assign sel_len     = tbl_len[region_q];
  assign len_round   = {1'b0, sel_len} + (LEN_W + 1)'(BYTES - 1);
  assign sel_beats   = len_round[LEN_W:OFF_W];
  assign sel_last    = (sel_len[OFF_W-1:0] == '0) ? CNT_W'(BYTES) : {1'b0, sel_len[OFF_W-1:0]};
  assign n_bytes     = (beats_q == BEAT_W'(1)) ? last_q : CNT_W'(BYTES);
  assign last_region = (region_q == IDX_W'(NUM_REGIONS - 1));
  assign ack         = avm_bus.avm_acknowledge;

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    mode_d      = mode_q;
    last_d      = last_q;
    shift_d     = shift_q;
    ucnt_d      = ucnt_q;
    tmo_d       = '0;
    byte_addr_d = wren_q ? byte_addr_q + 1'b1 : byte_addr_q;
    byte_data_d = byte_data_q;
    terr_d      = terr_q;

    // Abort overrides everything, including an acknowledge in the same cycle.
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = SEL;
            region_d    = '0;
            byte_addr_d = '0;
            terr_d      = 1'b0;
          end
        end
        SEL: begin
          if (!tbl_en[region_q] || sel_len == '0) begin
            if (last_region) state_d = FIN;
            else             region_d = region_q + 1'b1;
          end else begin
            addr_d  = tbl_base[region_q];
            beats_d = sel_beats;
            mode_d  = tbl_mode[region_q];
            last_d  = sel_last;
            state_d = REQ;
          end
        end
        REQ: begin
          if (!(mode_q && beat_full)) state_d = RD;
        end
        RD: begin
          if (ack) begin
            addr_d  = addr_q + ADDR_W'(BYTES);
            beats_d = beats_q - 1'b1;
            if (!mode_q) begin
              state_d     = UNPACK;
              byte_data_d = avm_bus.avm_readdata[7:0];
              shift_d     = avm_bus.avm_readdata >> 8;
              ucnt_d      = n_bytes - 1'b1;
            end else if (beats_q != BEAT_W'(1)) begin
              state_d = REQ;
            end else if (last_region) begin
              state_d = FIN;
            end else begin
              state_d  = SEL;
              region_d = region_q + 1'b1;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = FIN;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        UNPACK: begin
          // beats_q was already decremented on the acknowledge of this beat
          if (ucnt_q != '0) begin
            byte_data_d = shift_q[7:0];
            shift_d     = shift_q >> 8;
            ucnt_d      = ucnt_q - 1'b1;
          end else if (beats_q != '0) begin
            state_d = REQ;
          end else if (last_region) begin
            state_d = FIN;
          end else begin
            state_d  = SEL;
            region_d = region_q + 1'b1;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      region_q    <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      mode_q      <= 1'b0;
      last_q      <= '0;
      shift_q     <= '0;
      ucnt_q      <= '0;
      tmo_q       <= '0;
      byte_addr_q <= '0;
      byte_data_q <= '0;
      terr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_q      <= 1'b0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      ucnt_q      <= ucnt_d;
      tmo_q       <= tmo_d;
      byte_addr_q <= byte_addr_d;
      byte_data_q <= byte_data_d;
      terr_q      <= terr_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
      read_q      <= (state_d == RD);
      wren_q      <= (state_d == UNPACK);
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign region_idx             = region_q;
  assign timeout_err            = terr_q;
  assign avm_bus.avm_address    = addr_q;
  assign avm_bus.avm_read       = read_q;
  assign avm_bus.avm_byteenable = '1;
  assign byte_wren              = wren_q;
  assign byte_addr              = byte_addr_q;
  assign byte_data              = byte_data_q;
  assign beat_valid             = (state_q == RD) && mode_q && ack && !abort;
  assign beat_data              = avm_bus.avm_readdata;

endmodule

// File: tb/tb_avalon_region_reader.sv
// Directed bench for avalon_region_reader: byte/beat regions, skipping, timeout and abort.
module tb_avalon_region_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [25:0] cfg_base = '0;
  logic [19:0] cfg_len = '0;
  logic        cfg_mode = 1'b0;
  logic        cfg_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, timeout_err;
  logic [1:0]  region_idx;
  logic        byte_wren;
  logic [9:0]  byte_addr;
  logic [7:0]  byte_data;
  logic        beat_valid;
  logic [127:0] beat_data;
  logic        beat_full = 1'b0;

  avalon_region_reader_if #(.DATA_W(128), .ADDR_W(26)) bus ();

  avalon_region_reader #(.TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_mode(cfg_mode), .cfg_en(cfg_en), .start(start), .abort(abort),
    .busy(busy), .done(done), .region_idx(region_idx), .timeout_err(timeout_err),
    .avm_bus(bus),
    .byte_wren(byte_wren), .byte_addr(byte_addr), .byte_data(byte_data),
    .beat_valid(beat_valid), .beat_data(beat_data), .beat_full(beat_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_data(input logic [25:0] a);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(a + 26'(k));
    return d;
  endfunction

  // Memory model: acknowledges after ack_dly waiting cycles unless ack_off
  int ack_dly = 2;
  bit ack_off = 1'b0;
  int wait_cnt = 0;
  initial begin
    bus.avm_acknowledge = 1'b0;
    bus.avm_readdata = '0;
  end
  always @(posedge clk) begin
    #1;
    if (bus.avm_acknowledge) begin
      bus.avm_acknowledge = 1'b0;
      wait_cnt = 0;
    end else if (bus.avm_read && !ack_off) begin
      if (wait_cnt == ack_dly) begin
        bus.avm_acknowledge = 1'b1;
        bus.avm_readdata = mk_data(bus.avm_address);
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // beat_full toggles every 7 cycles while full_tog is set
  bit full_tog = 1'b0;
  int tcnt = 0;
  always @(posedge clk) begin
    #1;
    if (full_tog) begin
      if (tcnt == 6) begin tcnt = 0; beat_full = !beat_full; end
      else tcnt++;
    end else begin
      tcnt = 0;
      beat_full = 1'b0;
    end
  end

  // Monitor state
  logic [25:0] exp_addr[$];
  logic [1:0]  seq[$];
  int rd_cnt, addr_err, wr_cnt, werr, bv_cnt, bderr, done_cnt, full_err, drop_err;
  int cyc = 0, rise_cyc = 0, rd_len = 0;
  logic terr_fall = 1'b0;
  logic [9:0]  exp_waddr;
  logic [25:0] wbase, exp_baddr;
  bit chk_full = 1'b0, allow_drop = 1'b0;
  logic prev_read = 1'b0, prev_ack = 1'b0, prev_full = 1'b0, prev_busy = 1'b0;
  logic [1:0] last_ridx = '0;

  task automatic clr();
    exp_addr.delete();
    seq.delete();
    rd_cnt = 0; addr_err = 0; wr_cnt = 0; werr = 0; bv_cnt = 0; bderr = 0;
    done_cnt = 0; full_err = 0; drop_err = 0; exp_waddr = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.avm_read && !prev_read) begin
        rd_cnt++;
        rise_cyc = cyc;
        if (chk_full && prev_full) full_err++;
        if (exp_addr.size() == 0) addr_err++;
        else if (bus.avm_address != exp_addr.pop_front()) addr_err++;
      end
      if (prev_read && !bus.avm_read) begin
        rd_len = cyc - rise_cyc;
        terr_fall = timeout_err;
        if (!prev_ack && !allow_drop) drop_err++;
      end
      if (byte_wren) begin
        if (byte_addr != exp_waddr) werr++;
        if (byte_data != 8'(wbase + 26'(wr_cnt))) werr++;
        exp_waddr++;
        wr_cnt++;
      end
      if (beat_valid) begin
        if (beat_data != mk_data(exp_baddr)) bderr++;
        exp_baddr += 26'd16;
        bv_cnt++;
      end
      if (done) done_cnt++;
      if (busy && (!prev_busy || region_idx != last_ridx)) seq.push_back(region_idx);
    end
    last_ridx = region_idx;
    prev_busy = busy;
    prev_read = bus.avm_read;
    prev_ack  = bus.avm_acknowledge;
    prev_full = beat_full;
  end

  task automatic cfg(input int idx, input int base, input int len, input bit mode, input bit en);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_base = 26'(base); cfg_len = 20'(len);
    cfg_mode = mode; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_finished"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic push_reads(input int base, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(26'(base + 16 * i));
  endtask

  initial begin
    int n, wb, seqv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", bus.avm_read, 0);
    check("rst_byteen", bus.avm_byteenable, 16'hFFFF);
    check("rst_addr", bus.avm_address, 0);
    check("rst_wren", byte_wren, 0);
    check("rst_baddr", byte_addr, 0);
    check("rst_terr", timeout_err, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Byte-mode image region, 49 beats
    cfg(0, 204000, 784, 1'b0, 1'b1);
    clr(); wbase = 26'd204000; push_reads(204000, 49);
    run("img", 5000);
    check("img_reads", rd_cnt, 49);
    check("img_addr_err", addr_err, 0);
    check("img_writes", wr_cnt, 784);
    check("img_write_err", werr, 0);
    check("img_done", done_cnt, 1);
    check("img_drop", drop_err, 0);
    check("img_baddr_end", byte_addr, 784);

    // Partial last beat
    cfg(0, 256, 20, 1'b0, 1'b1);
    clr(); wbase = 26'd256; push_reads(256, 2);
    run("part", 500);
    check("part_reads", rd_cnt, 2);
    check("part_writes", wr_cnt, 20);
    check("part_write_err", werr, 0);
    check("part_baddr_end", byte_addr, 20);

    // Beat mode with backpressure
    cfg(0, 0, 0, 1'b0, 1'b0);
    cfg(1, 0, 203560, 1'b1, 1'b1);
    clr(); push_reads(0, 12723); exp_baddr = '0;
    ack_dly = 0; chk_full = 1'b1; full_tog = 1'b1;
    run("beat", 90000);
    full_tog = 1'b0; chk_full = 1'b0; ack_dly = 2;
    check("beat_valids", bv_cnt, 12723);
    check("beat_reads", rd_cnt, 12723);
    check("beat_addr_err", addr_err, 0);
    check("beat_data_err", bderr, 0);
    check("beat_full_err", full_err, 0);
    check("beat_drop", drop_err, 0);
    check("beat_done", done_cnt, 1);
    check("beat_no_writes", wr_cnt, 0);

    // Mixed and skipped regions
    cfg(0, 'h1000, 32, 1'b0, 1'b1);
    cfg(1, 'h2000, 64, 1'b0, 1'b0);
    cfg(2, 'h3000, 48, 1'b1, 1'b1);
    cfg(3, 'h4000, 0, 1'b0, 1'b1);
    clr(); wbase = 26'h1000; exp_baddr = 26'h3000;
    push_reads('h1000, 2); push_reads('h3000, 3);
    run("mix", 1000);
    seqv = 0;
    foreach (seq[i]) seqv = (seqv << 2) | int'(seq[i]);
    check("mix_seq_len", seq.size(), 4);
    check("mix_seq", seqv, 'h1B);
    check("mix_reads", rd_cnt, 5);
    check("mix_addr_err", addr_err, 0);
    check("mix_writes", wr_cnt, 32);
    check("mix_write_err", werr, 0);
    check("mix_beats", bv_cnt, 3);
    check("mix_beat_err", bderr, 0);
    check("mix_done", done_cnt, 1);

    // Timeout
    cfg(0, 'h500, 16, 1'b0, 1'b1);
    cfg(1, 0, 0, 1'b0, 1'b0);
    cfg(2, 0, 0, 1'b0, 1'b0);
    cfg(3, 0, 0, 1'b0, 1'b0);
    clr(); wbase = 26'h500; push_reads('h500, 1);
    ack_off = 1'b1; allow_drop = 1'b1;
    run("tmo", 200);
    check("tmo_read_len", rd_len, 10);
    check("tmo_err_at_drop", terr_fall, 1);
    check("tmo_err", timeout_err, 1);
    check("tmo_done", done_cnt, 1);
    check("tmo_writes", wr_cnt, 0);
    ack_off = 1'b0; allow_drop = 1'b0;
    clr(); push_reads('h500, 1);
    run("tmo_rerun", 500);
    check("tmo_cleared", timeout_err, 0);
    check("tmo_rerun_writes", wr_cnt, 16);
    check("tmo_rerun_done", done_cnt, 1);

    // start and abort together: abort wins
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", busy, 0);

    // Abort mid-UNPACK, then replay
    cfg(0, 'h600, 64, 1'b0, 1'b1);
    clr(); wbase = 26'h600; push_reads('h600, 4);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (wr_cnt < 5 && n < 500) begin @(negedge clk); n++; end
    check("abort_reached_unpack", wr_cnt >= 5, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_wren", byte_wren, 0);
    wb = wr_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_writes", wr_cnt, wb);
    check("abort_no_done", done_cnt, 0);
    clr(); push_reads('h600, 4);
    run("replay", 1000);
    check("replay_reads", rd_cnt, 4);
    check("replay_addr_err", addr_err, 0);
    check("replay_writes", wr_cnt, 64);
    check("replay_write_err", werr, 0);
    check("replay_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
